trap_sequencer: RTL and testbench

Machine-mode trap entry/exit controller for the riskproc core. It arbitrates between a synchronous exception request, three machine interrupt sources and `mret`, then sequences the resulting CSR updates one write per cycle through the single CSR write port. Sequenced CSRs: mepc, mcause, mtval, mstatus. When the sequence completes it redirects the fetch PC. It sits between the core control unit, the interrupt-pending logic and the CSR file.

---
 rtl/trap_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_trap_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: arbitrates exception, interrupts and mret,
// then drives the resulting CSR writes one per cycle and redirects fetch.
module trap_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            irq_ext,
    input  logic            irq_soft,
    input  logic            irq_timer,
    input  logic            instr_boundary,
    input  logic [XLEN-1:0] cur_pc,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SAVE_EPC   = 3'd1;
    localparam logic [2:0] SAVE_CAUSE = 3'd2;
    localparam logic [2:0] SAVE_TVAL  = 3'd3;
    localparam logic [2:0] UPD_STATUS = 3'd4;
    localparam logic [2:0] RET_STATUS = 3'd5;
    localparam logic [2:0] REDIRECT   = 3'd6;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] epc_q, cause_q, tval_q, status_q, target_q;
    logic            trap_q;

    logic            irq_take;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] tvec_base, tvec_off, status_trap, status_ret;

    // Interrupts are only considered between instructions, MEI > MSI > MTI.
    always_comb begin
        irq_take = 1'b0;
        irq_code = 5'd0;
        if (instr_boundary && mstatus[3]) begin
            if (irq_ext && mie[11]) begin
                irq_take = 1'b1;
                irq_code = 5'd11;
            end else if (irq_soft && mie[3]) begin
                irq_take = 1'b1;
                irq_code = 5'd3;
            end else if (irq_timer && mie[7]) begin
                irq_take = 1'b1;
                irq_code = 5'd7;
            end
        end
    end

    assign tvec_base = {mtvec[XLEN-1:2], 2'b00};
    assign tvec_off  = {{(XLEN-7){1'b0}}, irq_code, 2'b00};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (exc_valid || irq_take) begin
                    state_d = SAVE_EPC;
                end else if (mret_valid) begin
                    state_d = RET_STATUS;
                end
            end
            SAVE_EPC:   state_d = SAVE_CAUSE;
            SAVE_CAUSE: state_d = SAVE_TVAL;
            SAVE_TVAL:  state_d = UPD_STATUS;
            UPD_STATUS: state_d = REDIRECT;
            RET_STATUS: state_d = REDIRECT;
            REDIRECT:   state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            status_q <= '0;
            target_q <= '0;
            trap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (exc_valid) begin
                    epc_q    <= exc_pc;
                    cause_q  <= {{(XLEN-5){1'b0}}, exc_cause};
                    tval_q   <= exc_tval;
                    status_q <= mstatus;
                    target_q <= tvec_base;
                    trap_q   <= 1'b1;
                end else if (irq_take) begin
                    epc_q    <= cur_pc;
                    cause_q  <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
                    tval_q   <= '0;
                    status_q <= mstatus;
                    // Vectored mode only applies to interrupts; modes 2/3 act as direct.
                    target_q <= (mtvec[1:0] == 2'b01) ? tvec_base + tvec_off : tvec_base;
                    trap_q   <= 1'b1;
                end else if (mret_valid) begin
                    status_q <= mstatus;
                    target_q <= mepc;
                    trap_q   <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        status_trap        = status_q;
        status_trap[7]     = status_q[3];
        status_trap[3]     = 1'b0;
        status_trap[12:11] = 2'b11;
        status_ret         = status_q;
        status_ret[3]      = status_q[7];
        status_ret[7]      = 1'b1;
        status_ret[12:11]  = 2'b11;
    end

    // Outputs decode from state and latched snapshots only.
    always_comb begin
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        busy           = (state_q != IDLE);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap           = 1'b0;
        case (state_q)
            SAVE_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = {epc_q[XLEN-1:2], 2'b00};
            end
            SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause_q;
            end
            SAVE_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = tval_q;
            end
            UPD_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = status_trap;
            end
            RET_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = status_ret;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                trap           = trap_q;
            end
            default: ;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{epc_q[1:0], mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: table of request vectors, per-cycle scoreboard
// of expected CSR writes and redirects, plus a mid-sequence reset scenario.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_cause = '0;
    logic [31:0] exc_pc = '0, exc_tval = '0;
    logic        irq_ext = 1'b0, irq_soft = 1'b0, irq_timer = 1'b0;
    logic        instr_boundary = 1'b0;
    logic [31:0] cur_pc = '0;
    logic        mret_valid = 1'b0;
    logic [31:0] mstatus = '0, mie = '0, mtvec = '0, mepc = '0;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        busy, redirect_valid, trap;
    logic [31:0] redirect_pc;

    trap_sequencer #(.XLEN(32)) dut (
        .clk(clk), .resetn(resetn),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
        .instr_boundary(instr_boundary), .cur_pc(cur_pc), .mret_valid(mret_valid),
        .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc(mepc),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc_valid;
        logic [4:0]  exc_cause;
        logic [31:0] exc_pc, exc_tval;
        logic        irq_ext, irq_soft, irq_timer, boundary;
        logic [31:0] cur_pc;
        logic        mret;
        logic [31:0] mstatus, mie, mtvec, mepc;
        int          kind;  // 0 = nothing accepted, 1 = trap, 2 = mret
        logic [31:0] e_epc, e_cause, e_tval, e_status, e_target;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        is_redir;
        logic [11:0] addr;
        logic [31:0] data;
        logic        trap;
    } ev_t;

    ev_t  q[$];
    int   cyc = 0;
    int   busy_lo = 1, busy_hi = 0;
    int   n_checks = 0, n_fail = 0;
    vec_t vecs[14];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle monitor: every output is compared against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_ctrl", {28'd0, csr_we, busy, redirect_valid, trap}, 32'd0);
            chk("rst_data", csr_wdata | redirect_pc | {20'd0, csr_waddr}, 32'd0);
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_event @cyc %0d: got none expected addr 0x%03h data 0x%08h",
                         cyc, q[0].addr, q[0].data);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                ev_t ev;
                ev = q.pop_front();
                if (!ev.is_redir) begin
                    chk("csr_we", {31'd0, csr_we}, 32'd1);
                    chk("csr_waddr", {20'd0, csr_waddr}, {20'd0, ev.addr});
                    chk("csr_wdata", csr_wdata, ev.data);
                    chk("no_redirect", {31'd0, redirect_valid}, 32'd0);
                end else begin
                    chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
                    chk("redirect_pc", redirect_pc, ev.data);
                    chk("trap", {31'd0, trap}, {31'd0, ev.trap});
                    chk("no_we_on_redirect", {31'd0, csr_we}, 32'd0);
                end
            end else begin
                chk("idle_ctrl", {29'd0, csr_we, redirect_valid, trap}, 32'd0);
                chk("idle_data", csr_wdata | {20'd0, csr_waddr}, 32'd0);
            end
        end
    end

    task automatic clear_reqs();
        exc_valid = 1'b0;
        irq_ext = 1'b0;
        irq_soft = 1'b0;
        irq_timer = 1'b0;
        mret_valid = 1'b0;
        instr_boundary = 1'b0;
    endtask

    task automatic push_ev(input int c, input logic r, input logic [11:0] a,
                           input logic [31:0] d, input logic t);
        ev_t ev;
        ev.cyc = c;
        ev.is_redir = r;
        ev.addr = a;
        ev.data = d;
        ev.trap = t;
        q.push_back(ev);
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        int len;
        @(negedge clk);
        #1;
        exc_valid = v.exc_valid;
        exc_cause = v.exc_cause;
        exc_pc = v.exc_pc;
        exc_tval = v.exc_tval;
        irq_ext = v.irq_ext;
        irq_soft = v.irq_soft;
        irq_timer = v.irq_timer;
        instr_boundary = v.boundary;
        cur_pc = v.cur_pc;
        mret_valid = v.mret;
        mstatus = v.mstatus;
        mie = v.mie;
        mtvec = v.mtvec;
        mepc = v.mepc;
        a = cyc + 1;
        len = 0;
        if (v.kind == 1) begin
            push_ev(a,     1'b0, 12'h341, v.e_epc, 1'b0);
            push_ev(a + 1, 1'b0, 12'h342, v.e_cause, 1'b0);
            push_ev(a + 2, 1'b0, 12'h343, v.e_tval, 1'b0);
            push_ev(a + 3, 1'b0, 12'h300, v.e_status, 1'b0);
            push_ev(a + 4, 1'b1, 12'h000, v.e_target, 1'b1);
            len = 5;
        end else if (v.kind == 2) begin
            push_ev(a,     1'b0, 12'h300, v.e_status, 1'b0);
            push_ev(a + 1, 1'b1, 12'h000, v.e_target, 1'b0);
            len = 2;
        end
        if (len > 0) begin
            busy_lo = a;
            busy_hi = a + len - 1;
        end
        @(negedge clk);
        #1;
        clear_reqs();
        if (len > 0) begin
            // Hammer the request and CSR inputs while busy; none of it may leak through.
            exc_valid = 1'b1;
            exc_cause = 5'($urandom);
            irq_ext = 1'b1;
            irq_soft = 1'b1;
            irq_timer = 1'b1;
            instr_boundary = 1'b1;
            mret_valid = 1'b1;
            mstatus = $urandom | 32'h8;
            mie = $urandom;
            mtvec = $urandom;
            mepc = $urandom;
            exc_pc = $urandom;
            exc_tval = $urandom;
            cur_pc = $urandom;
            repeat (len - 1) @(negedge clk);
            #1;
            clear_reqs();
        end
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        chk("drain", q.size(), 32'd0);
        q.delete();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 5, 'h100, 'h203, 0, 0, 0, 0, 0, 0, 'h8, 0, 'h800, 0,
                     1, 'h100, 5, 'h203, 'h1880, 'h800};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 1, 1, 'h40, 0, 'h8, 'h80, 'h1001, 0,
                     1, 'h40, 'h80000007, 0, 'h1880, 'h101C};
        vecs[2]  = '{1, 4, 'h203, 'h55, 1, 0, 0, 1, 'h999, 1, 'h8, 'h800, 'h1001, 'h700,
                     1, 'h200, 4, 'h55, 'h1880, 'h1000};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 'h60, 0, 'h8, 'h800, 'h1001, 0,
                     0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1880, 0, 'h800, 'h104,
                     2, 0, 0, 0, 'h1888, 'h104};
        vecs[5]  = '{0, 0, 0, 0, 1, 1, 1, 1, 'h300, 0, 'h8, 'h888, 'h2001, 0,
                     1, 'h300, 'h8000000B, 0, 'h1880, 'h202C};
        vecs[6]  = '{0, 0, 0, 0, 0, 1, 1, 1, 'h444, 0, 'h8, 'h88, 'h2001, 0,
                     1, 'h444, 'h80000003, 0, 'h1880, 'h200C};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 1, 1, 'h50, 0, 'hA, 'h80, 'h3003, 0,
                     1, 'h50, 'h80000007, 0, 'h1882, 'h3000};
        vecs[8]  = '{0, 0, 0, 0, 1, 0, 0, 1, 'h60, 0, 'h0, 'h800, 'h1001, 0,
                     0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hFFFFFF77, 0, 0, 'h20000000,
                     2, 0, 0, 0, 'hFFFFFFF7, 'h20000000};
        vecs[10] = '{1, 0, 'hFFFFFFFE, 'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFFFFFD, 0,
                     1, 'hFFFFFFFC, 0, 'hDEADBEEF, 'h1800, 'hFFFFFFFC};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 'h7, 0, 'h8, 'h80, 'hFFFFFFF1, 0,
                     1, 'h4, 'h80000007, 0, 'h1880, 'hC};
        vecs[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 'h80, 1, 'h1888, 'h800, 0, 'h104,
                     2, 0, 0, 0, 'h1888, 'h104};
        vecs[13] = '{0, 0, 0, 0, 1, 0, 0, 1, 'h900, 1, 'h8, 'h800, 'h400, 'h50,
                     1, 'h900, 'h8000000B, 0, 'h1880, 'h400};

        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted while SAVE_CAUSE is on the write port.
        begin
            int a;
            @(negedge clk);
            #1;
            exc_valid = 1'b1;
            exc_cause = 5'd6;
            exc_pc = 32'h500;
            exc_tval = 32'h77;
            mtvec = 32'h600;
            mstatus = 32'h8;
            a = cyc + 1;
            push_ev(a,     1'b0, 12'h341, 32'h500, 1'b0);
            push_ev(a + 1, 1'b0, 12'h342, 32'h6, 1'b0);
            busy_lo = a;
            busy_hi = a + 1;
            @(negedge clk);
            #1;
            clear_reqs();
            @(negedge clk);
            #1;
            resetn = 1'b0;
            #1;
            chk("async_rst_we", {31'd0, csr_we}, 32'd0);
            chk("async_rst_busy", {31'd0, busy}, 32'd0);
            chk("async_rst_waddr", {20'd0, csr_waddr}, 32'd0);
            chk("async_rst_wdata", csr_wdata, 32'd0);
            chk("async_rst_redirect", {30'd0, redirect_valid, trap}, 32'd0);
            chk("async_rst_pc", redirect_pc, 32'd0);
            chk("pre_rst_events", q.size(), 32'd0);
            q.delete();
            repeat (3) @(negedge clk);
            #1;
            resetn = 1'b1;
            @(negedge clk);
            run_vec(vecs[0]);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
